// File: rtl/tpu_pkg.sv
// Shared TPU package: DMA FSM state encoding, element-size codes with their
// byte counts, transfer direction constants and command field widths.
package tpu_pkg;

   localparam int unsigned DMA_LEN_W = 16;
   localparam int unsigned DMA_SZ_W  = 2;

   localparam logic DMA_DIR_H2D = 1'b0;
   localparam logic DMA_DIR_D2H = 1'b1;

   typedef enum logic [DMA_SZ_W-1:0] {
      ELEM_SZ_1B   = 2'b00,
      ELEM_SZ_2B   = 2'b01,
      ELEM_SZ_4B   = 2'b10,
      ELEM_SZ_RSVD = 2'b11
   } dma_elem_sz_e;

   typedef enum logic [2:0] {
      DMA_ST_IDLE,
      DMA_ST_SETUP,
      DMA_ST_H2D,
      DMA_ST_D2H,
      DMA_ST_DONE
   } dma_state_e;

   // Bytes per element; the reserved code yields zero.
   function automatic logic [2:0] elem_bytes(input logic [DMA_SZ_W-1:0] sz);
      case (sz)
         ELEM_SZ_1B: return 3'd1;
         ELEM_SZ_2B: return 3'd2;
         ELEM_SZ_4B: return 3'd4;
         default:    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/tpu_dma_skid.sv
// Two-entry valid/ready FIFO feeding the D2H host stream; absorbs UB read
// data that is already in flight when the host stalls.
module tpu_dma_skid #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              do_push;
   logic              do_pop;

   // Qualify push/pop against occupancy; a push into a full FIFO is only
   // accepted when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop_i && (count_q != 2'd0);
      do_push = push_i && ((count_q != 2'd2) || do_pop);
   end

   // Storage, pointers and occupancy; reset flushes contents to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;

endmodule

// File: rtl/tpu_dma_engine.sv
// DMA responder between the host word streams and the unified buffer.
// Optional TPU_DMA_PERF_EN adds saturating busy/stall cycle counters.
module tpu_dma_engine
   import tpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned UB_AW  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dma_start,
   input  logic                 dma_dir,
   input  logic [UB_AW-1:0]     dma_ub_addr,
   input  logic [DMA_LEN_W-1:0] dma_length,
   input  logic [DMA_SZ_W-1:0]  dma_elem_sz,
   output logic                 dma_busy,
   output logic                 dma_done,
   output logic                 dma_err,
   input  logic                 h2d_valid,
   input  logic [DATA_W-1:0]    h2d_data,
   output logic                 h2d_ready,
   output logic                 d2h_valid,
   output logic [DATA_W-1:0]    d2h_data,
   input  logic                 d2h_ready,
   output logic                 ub_wr_en,
   output logic [UB_AW-1:0]     ub_wr_addr,
   output logic [DATA_W-1:0]    ub_wr_data,
   output logic                 ub_rd_en,
   output logic [UB_AW-1:0]     ub_rd_addr,
   input  logic [DATA_W-1:0]    ub_rd_data
`ifdef TPU_DMA_PERF_EN
   ,
   output logic [31:0]          perf_busy_cycles,
   output logic [31:0]          perf_stall_cycles
`endif
);

   localparam int unsigned BPW = DATA_W / 8;

   dma_state_e           state_q;
   dma_elem_sz_e         sz_q;
   logic                 dir_q;
   logic [UB_AW-1:0]     addr_q;
   logic [DMA_LEN_W-1:0] len_q;
   logic [DMA_LEN_W-1:0] rem_q;
   logic [DMA_LEN_W-1:0] rd_left_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;
   logic                 h2d_ready_q;
   logic                 inflight_q;

   logic [17:0]          total_bytes;
   logic [17:0]          tail_bytes;
   logic [DMA_LEN_W-1:0] nwords_d;
   logic                 h2d_fire;
   logic                 d2h_fire;
   logic                 rd_go;
   logic [2:0]           occ_after;
   logic                 fifo_valid;
   logic                 fifo_full;
   logic [1:0]           fifo_count;
   logic [DATA_W-1:0]    fifo_data;

   // Word count of the latched command, rounded up to whole words.
   always_comb begin
      total_bytes = 18'(len_q) * 18'(elem_bytes(sz_q));
      tail_bytes  = total_bytes % 18'(BPW);
      nwords_d    = DMA_LEN_W'(total_bytes / 18'(BPW)) + DMA_LEN_W'(tail_bytes != '0);
   end

   // Stream handshakes and UB read issue. A read is allowed when the FIFO,
   // after this cycle's pop, still has room for it plus the read in flight;
   // counting the pop is what sustains one word per cycle.
   always_comb begin
      h2d_fire  = h2d_ready_q && h2d_valid;
      d2h_fire  = fifo_valid && d2h_ready;
      occ_after = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, d2h_fire};
      rd_go     = (state_q == DMA_ST_D2H) && (rd_left_q != '0) &&
                  (occ_after <= 3'd1) && !(fifo_full && !d2h_fire);
   end

   // Command FSM with registered status outputs and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DMA_ST_IDLE;
         sz_q        <= ELEM_SZ_1B;
         dir_q       <= DMA_DIR_H2D;
         addr_q      <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         rd_left_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         h2d_ready_q <= 1'b0;
         inflight_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= rd_go;
         if (dma_start && (state_q != DMA_ST_IDLE)) begin
            err_q <= 1'b1;
         end
         case (state_q)
            DMA_ST_IDLE: begin
               if (dma_start) begin
                  dir_q   <= dma_dir;
                  addr_q  <= dma_ub_addr;
                  len_q   <= dma_length;
                  sz_q    <= dma_elem_sz_e'(dma_elem_sz);
                  busy_q  <= 1'b1;
                  state_q <= DMA_ST_SETUP;
               end
            end
            DMA_ST_SETUP: begin
               rem_q     <= nwords_d;
               rd_left_q <= nwords_d;
               if (sz_q == ELEM_SZ_RSVD) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DMA_ST_DONE;
               end else if (nwords_d == '0) begin
                  done_q  <= 1'b1;
                  state_q <= DMA_ST_DONE;
               end else if (dir_q == DMA_DIR_H2D) begin
                  h2d_ready_q <= 1'b1;
                  state_q     <= DMA_ST_H2D;
               end else begin
                  state_q <= DMA_ST_D2H;
               end
            end
            DMA_ST_H2D: begin
               if (h2d_fire) begin
                  addr_q <= addr_q + 1'b1;
                  rem_q  <= rem_q - 1'b1;
                  if (rem_q == DMA_LEN_W'(1)) begin
                     h2d_ready_q <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= DMA_ST_DONE;
                  end
               end
            end
            DMA_ST_D2H: begin
               if (rd_go) begin
                  addr_q    <= addr_q + 1'b1;
                  rd_left_q <= rd_left_q - 1'b1;
               end
               if (d2h_fire) begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == DMA_LEN_W'(1)) begin
                     done_q  <= 1'b1;
                     state_q <= DMA_ST_DONE;
                  end
               end
            end
            DMA_ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= DMA_ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= DMA_ST_IDLE;
            end
         endcase
      end
   end

   tpu_dma_skid #(
      .DATA_W(DATA_W)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_data_i(ub_rd_data),
      .pop_i      (d2h_fire),
      .valid_o    (fifo_valid),
      .data_o     (fifo_data),
      .full_o     (fifo_full),
      .count_o    (fifo_count)
   );

   assign dma_busy   = busy_q;
   assign dma_done   = done_q;
   assign dma_err    = err_q;
   assign h2d_ready  = h2d_ready_q;
   assign ub_wr_en   = h2d_fire;
   assign ub_wr_addr = addr_q;
   assign ub_wr_data = h2d_fire ? h2d_data : '0;
   assign ub_rd_en   = rd_go;
   assign ub_rd_addr = addr_q;
   assign d2h_valid  = fifo_valid;
   assign d2h_data   = fifo_data;

`ifdef TPU_DMA_PERF_EN
   logic [31:0] perf_busy_q;
   logic [31:0] perf_stall_q;
   logic        stall_cycle;

   assign stall_cycle = ((state_q == DMA_ST_H2D) && !h2d_fire) ||
                        ((state_q == DMA_ST_D2H) && !d2h_fire);

   // Saturating busy and stream-stall cycle counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (busy_q && (perf_busy_q != '1)) begin
            perf_busy_q <= perf_busy_q + 1'b1;
         end
         if (stall_cycle && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 1'b1;
         end
      end
   end

   assign perf_busy_cycles  = perf_busy_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_tpu_dma_engine.sv
// Self-checking bench for tpu_dma_engine: directed table, wrap/stall,
// mid-transfer start and reset sequences, then randomized commands against
// a word-level reference model of the UB contents.
module tb_tpu_dma_engine;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          dma_start;
   logic          dma_dir;
   logic [AW-1:0] dma_ub_addr;
   logic [15:0]   dma_length;
   logic [1:0]    dma_elem_sz;
   logic          dma_busy;
   logic          dma_done;
   logic          dma_err;
   logic          h2d_valid;
   logic [DW-1:0] h2d_data;
   logic          h2d_ready;
   logic          d2h_valid;
   logic [DW-1:0] d2h_data;
   logic          d2h_ready;
   logic          ub_wr_en;
   logic [AW-1:0] ub_wr_addr;
   logic [DW-1:0] ub_wr_data;
   logic          ub_rd_en;
   logic [AW-1:0] ub_rd_addr;
   logic [DW-1:0] ub_rd_data;

   always #5 clk = ~clk;

   tpu_dma_engine #(
      .DATA_W(DW),
      .UB_AW (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dma_start  (dma_start),
      .dma_dir    (dma_dir),
      .dma_ub_addr(dma_ub_addr),
      .dma_length (dma_length),
      .dma_elem_sz(dma_elem_sz),
      .dma_busy   (dma_busy),
      .dma_done   (dma_done),
      .dma_err    (dma_err),
      .h2d_valid  (h2d_valid),
      .h2d_data   (h2d_data),
      .h2d_ready  (h2d_ready),
      .d2h_valid  (d2h_valid),
      .d2h_data   (d2h_data),
      .d2h_ready  (d2h_ready),
      .ub_wr_en   (ub_wr_en),
      .ub_wr_addr (ub_wr_addr),
      .ub_wr_data (ub_wr_data),
      .ub_rd_en   (ub_rd_en),
      .ub_rd_addr (ub_rd_addr),
      .ub_rd_data (ub_rd_data)
   );

   // Unified buffer behaviour: write on the handshake edge, read data one
   // cycle after the read enable.
   logic [DW-1:0] ub_mem [256];
   logic          mem_init = 1'b1;

   function automatic logic [31:0] seed_word(input int a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) ub_mem[i] <= seed_word(i);
         ub_rd_data <= '0;
      end else begin
         if (ub_wr_en) ub_mem[ub_wr_addr] <= ub_wr_data;
         if (ub_rd_en) ub_rd_data <= ub_mem[ub_rd_addr];
      end
   end

   // Reference model state: expected UB contents and sticky error.
   logic [31:0] mem_model [256];
   logic        err_model;

   function automatic int model_nwords(input int len, input int sz);
      if (sz == 3) return 0;
      return (len * (1 << sz) + (DW / 8) - 1) / (DW / 8);
   endfunction

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver controls
   logic        rst_req   = 1'b1;
   logic        start_req = 1'b0;
   logic        st_dir;
   logic [7:0]  st_addr;
   logic [15:0] st_len;
   logic [1:0]  st_sz;
   int          valid_pct  = 100;
   int          ready_mode = 0;
   int          cyc        = 0;
   int          h2d_idx    = 0;
   logic [31:0] h2d_words [$];

   // Monitor logs
   logic [7:0]  wr_addr_log [$];
   logic [31:0] wr_data_log [$];
   logic [7:0]  rd_addr_log [$];
   logic [31:0] d2h_log     [$];
   int          busy_cnt   = 0;
   int          done_cnt   = 0;
   int          hold_viol  = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_addr_log.delete();
      d2h_log.delete();
      busy_cnt  = 0;
      done_cnt  = 0;
      hold_viol = 0;
   endtask

   // One clock cycle: drive just after the rising edge, observe at the
   // falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      rst       = rst_req;
      dma_start = start_req;
      if (start_req) begin
         dma_dir     = st_dir;
         dma_ub_addr = st_addr;
         dma_length  = st_len;
         dma_elem_sz = st_sz;
         start_req   = 1'b0;
      end
      if ((h2d_idx < h2d_words.size()) && ($urandom_range(99) < 32'(valid_pct))) begin
         h2d_valid = 1'b1;
         h2d_data  = h2d_words[h2d_idx];
      end else begin
         h2d_valid = 1'b0;
         h2d_data  = $urandom;
      end
      case (ready_mode)
         0:       d2h_ready = 1'b1;
         1:       d2h_ready = cyc[0];
         2:       d2h_ready = 1'($urandom_range(1));
         default: d2h_ready = 1'b0;
      endcase
      @(negedge clk);
      if (dma_busy) busy_cnt++;
      if (dma_done) done_cnt++;
      if (ub_wr_en) begin
         wr_addr_log.push_back(ub_wr_addr);
         wr_data_log.push_back(ub_wr_data);
      end
      if (ub_rd_en) rd_addr_log.push_back(ub_rd_addr);
      if (d2h_valid && d2h_ready) d2h_log.push_back(d2h_data);
      if (prev_stall && (!d2h_valid || (d2h_data !== prev_data))) hold_viol++;
      prev_stall = d2h_valid && !d2h_ready && !rst;
      prev_data  = d2h_data;
      if (h2d_valid && h2d_ready) h2d_idx++;
      cyc++;
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      step();
      rst_req   = 1'b0;
      err_model = 1'b0;
      h2d_words.delete();
      step();
   endtask

   // Issue one command, run it to completion and compare everything the
   // model predicts. exp_busy < 0 skips the busy-length comparison;
   // inject_at >= 0 fires a second start that many cycles into the transfer.
   task automatic run_cmd(input logic dir, input int addr, input int len, input int sz,
                          input int exp_nw, input int exp_busy, input int vpct,
                          input int rmode, input int inject_at, input string tag);
      int n;
      int bad;
      logic [7:0] a8;
      clear_logs();
      h2d_words.delete();
      h2d_idx = 0;
      if (dir == 1'b0) begin
         for (int i = 0; i < exp_nw; i++) h2d_words.push_back($urandom);
      end
      valid_pct  = vpct;
      ready_mode = rmode;
      st_dir     = dir;
      st_addr    = 8'(addr);
      st_len     = 16'(len);
      st_sz      = 2'(sz);
      start_req  = 1'b1;
      step();
      if (sz == 3) err_model = 1'b1;
      n = 0;
      while ((done_cnt == 0) && (n < 400)) begin
         if (n == inject_at) begin
            st_dir    = ~dir;
            st_addr   = 8'h00;
            st_len    = 16'd100;
            st_sz     = 2'd2;
            start_req = 1'b1;
            err_model = 1'b1;
         end
         step();
         n++;
      end
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      step();
      check({tag, "_busy_low_after_done"}, 32'(dma_busy), 32'd0);
      check({tag, "_single_done"}, 32'(done_cnt), 32'd1);
      if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_ub_writes"}, 32'(wr_addr_log.size()), (dir == 1'b0) ? 32'(exp_nw) : 32'd0);
      check({tag, "_ub_reads"}, 32'(rd_addr_log.size()), (dir == 1'b1) ? 32'(exp_nw) : 32'd0);
      check({tag, "_d2h_beats"}, 32'(d2h_log.size()), (dir == 1'b1) ? 32'(exp_nw) : 32'd0);
      bad = 0;
      for (int i = 0; i < exp_nw; i++) begin
         a8 = 8'(addr + i);
         if (dir == 1'b0) begin
            if ((i >= wr_addr_log.size()) || (wr_addr_log[i] !== a8) ||
                (wr_data_log[i] !== h2d_words[i])) bad++;
            mem_model[a8] = h2d_words[i];
         end else begin
            if ((i >= rd_addr_log.size()) || (rd_addr_log[i] !== a8)) bad++;
            if ((i >= d2h_log.size()) || (d2h_log[i] !== mem_model[a8])) bad++;
         end
      end
      check({tag, "_addr_data_mismatches"}, 32'(bad), 32'd0);
      check({tag, "_d2h_hold_violations"}, 32'(hold_viol), 32'd0);
      check({tag, "_err"}, 32'(dma_err), 32'(err_model));
   endtask

   typedef struct {
      logic dir;
      int   addr;
      int   len;
      int   sz;
      int   exp_nw;
      int   exp_busy;
      logic exp_err;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      logic r_dir;
      int r_addr, r_len, r_sz;

      tbl[0] = '{dir: 1'b0, addr: 'h10, len: 8, sz: 2, exp_nw: 8, exp_busy: 10, exp_err: 1'b0};
      tbl[1] = '{dir: 1'b0, addr: 'h20, len: 5, sz: 0, exp_nw: 2, exp_busy: 4,  exp_err: 1'b0};
      tbl[2] = '{dir: 1'b1, addr: 'h30, len: 3, sz: 1, exp_nw: 2, exp_busy: 6,  exp_err: 1'b0};
      tbl[3] = '{dir: 1'b0, addr: 'h40, len: 0, sz: 2, exp_nw: 0, exp_busy: 2,  exp_err: 1'b0};
      tbl[4] = '{dir: 1'b1, addr: 'h50, len: 7, sz: 0, exp_nw: 2, exp_busy: 6,  exp_err: 1'b0};
      tbl[5] = '{dir: 1'b0, addr: 'hFF, len: 3, sz: 2, exp_nw: 3, exp_busy: 5,  exp_err: 1'b0};
      tbl[6] = '{dir: 1'b1, addr: 'h00, len: 1, sz: 2, exp_nw: 1, exp_busy: 5,  exp_err: 1'b0};
      tbl[7] = '{dir: 1'b1, addr: 'h60, len: 4, sz: 3, exp_nw: 0, exp_busy: 2,  exp_err: 1'b1};

      for (int i = 0; i < 256; i++) mem_model[i] = seed_word(i);
      err_model   = 1'b0;
      rst         = 1'b1;
      dma_start   = 1'b0;
      dma_dir     = 1'b0;
      dma_ub_addr = '0;
      dma_length  = '0;
      dma_elem_sz = '0;
      h2d_valid   = 1'b0;
      h2d_data    = '0;
      d2h_ready   = 1'b0;

      step();
      mem_init = 1'b0;
      step();
      check("reset_ctrl_outputs",
            32'({dma_busy, dma_done, dma_err, h2d_ready, d2h_valid, ub_wr_en, ub_rd_en}), 32'd0);
      check("reset_addresses", 32'({ub_wr_addr, ub_rd_addr}), 32'd0);
      check("reset_d2h_data", d2h_data, 32'd0);
      check("reset_ub_wr_data", ub_wr_data, 32'd0);
      rst_req = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_cmd(tbl[i].dir, tbl[i].addr, tbl[i].len, tbl[i].sz, tbl[i].exp_nw,
                 tbl[i].exp_busy, 100, 0, -1, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_err_table", i), 32'(dma_err), 32'(tbl[i].exp_err));
      end

      do_reset();
      check("err_cleared_by_reset", 32'(dma_err), 32'd0);

      // D2H across the address wrap with the host stalling every other cycle.
      run_cmd(1'b1, 'hFE, 4, 2, 4, -1, 100, 1, -1, "d2h_wrap_toggle");

      // Second start while an H2D transfer is running.
      run_cmd(1'b0, 'h70, 8, 2, 8, 10, 100, 0, 4, "h2d_inject");
      check("h2d_inject_err_set", 32'(dma_err), 32'd1);

      // Reset in the middle of a D2H transfer with three words still owed.
      clear_logs();
      h2d_words.delete();
      ready_mode = 0;
      st_dir     = 1'b1;
      st_addr    = 8'h80;
      st_len     = 16'd6;
      st_sz      = 2'd2;
      start_req  = 1'b1;
      step();
      n = 0;
      while ((d2h_log.size() < 3) && (n < 100)) begin
         step();
         n++;
      end
      check("rst_mid_beats_before", 32'(d2h_log.size()), 32'd3);
      ready_mode = 3;
      rst_req    = 1'b1;
      step();
      rst_req    = 1'b0;
      ready_mode = 0;
      err_model  = 1'b0;
      step();
      check("rst_mid_outputs_idle", 32'({dma_busy, d2h_valid, ub_rd_en, dma_err}), 32'd0);
      step();
      step();
      check("rst_mid_no_done", 32'(done_cnt), 32'd0);
      run_cmd(1'b0, 'h90, 4, 2, 4, 6, 100, 0, -1, "after_rst");

      // Randomized commands with random host valid/ready behaviour.
      for (int k = 0; k < 24; k++) begin
         r_dir  = 1'($urandom_range(1));
         r_addr = int'($urandom_range(255));
         r_sz   = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
         r_len  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(48, 1));
         run_cmd(r_dir, r_addr, r_len, r_sz, model_nwords(r_len, r_sz), -1,
                 int'($urandom_range(100, 40)), 2, -1, $sformatf("rand%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tpu_dma_engine.md
# tpu_dma_engine

Responder for the controller's DMA command interface: accepts the one-cycle `dma_start` command (direction, UB address, element count, element size), moves the data between the host word streams and the unified buffer (UB), and drives `dma_busy` back to the controller for hazard stalling. Sits between the host link and the UB ports, beside the systolic array and VPU.

## Interface
- `DATA_W`, 32: host stream and UB word width in bits (multiple of 8, min 32)
- `UB_AW`, 8: UB address width
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `dma_start` in 1: command strobe, one cycle
- `dma_dir` in 1: 0 host->TPU (H2D), 1 TPU->host (D2H)
- `dma_ub_addr` in UB_AW: first UB word address
- `dma_length` in 16: element count
- `dma_elem_sz` in 2: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 reserved
- `dma_busy` out 1: command in progress
- `dma_done` out 1: one-cycle completion pulse
- `dma_err` out 1: sticky error flag, cleared only by `rst`
- `h2d_valid` in 1 / `h2d_data` in DATA_W / `h2d_ready` out 1: host input stream
- `d2h_valid` out 1 / `d2h_data` out DATA_W / `d2h_ready` in 1: host output stream
- `ub_wr_en` out 1 / `ub_wr_addr` out UB_AW / `ub_wr_data` out DATA_W: UB write port
- `ub_rd_en` out 1 / `ub_rd_addr` out UB_AW / `ub_rd_data` in DATA_W: UB read port, data valid 1 cycle after `ub_rd_en`

## Operation
- FSM states: IDLE, SETUP, H2D, D2H, DONE.
- IDLE: on `dma_start` latch all command fields -> SETUP.
- SETUP: compute word count `nwords = ceil(dma_length * bytes / (DATA_W/8))`, using an 18-bit intermediate and a 16-bit result. If `dma_elem_sz == 11`: set `dma_err` -> DONE. If `nwords == 0` -> DONE. Otherwise -> H2D or D2H according to `dma_dir`.
- H2D: `h2d_ready` = 1. On each `h2d_valid && h2d_ready`: write the word to UB at the current address, increment the address, decrement the remaining count. After the last word -> DONE.
- D2H: issue a UB read whenever words remain and the skid FIFO has space for (occupancy + reads in flight). Returned data is pushed into a 2-entry FIFO that drives `d2h_*`. Once the last word is accepted by the host -> DONE.
- DONE: `dma_done` = 1 for one cycle -> IDLE.
- Address increment wraps modulo 2^UB_AW (255 -> 0). The wrap is not an error.
- Only full words are transferred. In H2D, tail bytes of the last word are written as received. In D2H, they are read as stored.
- `dma_start` outside IDLE: the command is ignored and `dma_err` is set. The current transfer continues unaffected.

## Timing
- Reset values: `dma_busy`, `dma_done`, `dma_err`, `h2d_ready`, `d2h_valid`, `ub_wr_en`, `ub_rd_en` = 0. All address and data outputs = 0. Skid FIFO empty. State = IDLE.
- `dma_busy` rises the cycle after `dma_start` is sampled and stays high through the DONE cycle. It is low the cycle after `dma_done`.
- Zero-length or reserved-size command: busy for exactly 2 cycles (SETUP, DONE).
- H2D: UB write occurs on the same cycle as the stream handshake (`ub_wr_*` are combinational from the handshake and registered address). Throughput is 1 word/cycle.
- D2H: the first `d2h_valid` appears 2 cycles after entering D2H. Throughput is 1 word/cycle while `d2h_ready` = 1. `d2h_data` is held stable while `d2h_valid && !d2h_ready`.
- Reset mid-transfer: immediate return to IDLE, FIFO flushed, no `dma_done`. Partially written UB contents are left as is.

## Configuration
- `TPU_DMA_PERF_EN` defined: adds outputs `perf_busy_cycles` (32 b) and `perf_stall_cycles` (32 b).
  - `perf_busy_cycles` counts cycles with `dma_busy` high.
  - `perf_stall_cycles` counts H2D/D2H cycles with no stream handshake.
  - Both are saturating, cleared by `rst` only.
- `TPU_DMA_PERF_EN` undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package `tpu_pkg`:
  - FSM state encoding
  - elem-size codes and byte-count lookup
  - `DMA_DIR_H2D`/`DMA_DIR_D2H` constants
  - command field widths, shared with `tpu_controller`
- One sub-module: `tpu_dma_skid`, a 2-entry valid/ready FIFO with `push`, `pop`, `full`, `count`. Used on the D2H path.

## Test plan
- H2D, addr 0x10, length 8, elem_sz 10, host valid every cycle -> 8 UB writes to 0x10..0x17 on consecutive cycles; busy for 10 cycles; one `dma_done`.
- D2H, addr 0xFE, length 4, elem_sz 10, `d2h_ready` toggling 1/0 -> reads 0xFE, 0xFF, 0x00, 0x01 in order; exactly 4 `d2h` handshakes; data held during stalls; `dma_err` = 0.
- Packing: length 5, elem_sz 00 (5 B) -> nwords = 2; length 3, elem_sz 01 (6 B) -> nwords = 2.
- Length 0, then elem_sz 11 with length 4 -> each busy 2 cycles with one `dma_done`; no UB traffic; `dma_err` = 0 after the first, 1 after the second.
- `dma_start` issued mid-H2D -> ignored, `dma_err` = 1, original transfer completes with correct word count.
- `rst` asserted during D2H with 3 words left -> next cycle busy = 0, `d2h_valid` = 0; no `dma_done`; a subsequent command completes normally.
